// File: rtl/reg_chain_sum_pkg.sv
// Shared constants and helpers for the reg_chain_sum pipeline and its stage.
package reg_chain_sum_pkg;

   localparam int unsigned MAX_CHANNELS = 16;
   localparam int unsigned MAX_DEPTH    = 8;

   function automatic bit params_legal(input int unsigned channels,
                                       input int unsigned depth,
                                       input int unsigned data_width,
                                       input int unsigned out_width);
      return (channels >= 1) && (channels <= MAX_CHANNELS) &&
             (depth >= 1) && (depth <= MAX_DEPTH) &&
             (data_width >= 1) && (out_width >= data_width);
   endfunction

   // Bit offset of a lane inside the packed lane vector.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/reg_chain_sum_stage.sv
// One pipeline stage: CHANNELS lanes plus a valid bit.
// Data only loads on a valid beat so bubbles leave the previous contents in place.
module reg_chain_sum_stage #(
   parameter int unsigned LANES_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clr,
   input  logic               i_adv,
   input  logic [LANES_W-1:0] i_data,
   input  logic               i_vld,
   output logic [LANES_W-1:0] o_data,
   output logic               o_vld
);

   logic [LANES_W-1:0] r_data;
   logic               r_vld;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_data <= '0;
         r_vld  <= 1'b0;
      end else if (i_clr) begin
         r_vld <= 1'b0;
      end else if (i_adv) begin
         r_vld <= i_vld;
         if (i_vld) begin
            r_data <= i_data;
         end
      end
   end

   assign o_data = r_data;
   assign o_vld  = r_vld;

endmodule

// File: rtl/reg_chain_sum_pipe.sv
// DEPTH-stage lane-parallel register chain with bubble-collapsing backpressure,
// a modular lane sum on the last stage and a delivered-result counter.
module reg_chain_sum_pipe
   import reg_chain_sum_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
   input  logic                           in_vld,
   output logic                           in_rdy,
   input  logic                           clr,
   output logic [OUT_WIDTH-1:0]           out_data,
   output logic                           out_vld,
   input  logic                           out_rdy,
   output logic [CNT_WIDTH-1:0]           out_cnt
);

   localparam int unsigned LANES_W = CHANNELS * DATA_WIDTH;

   if (!params_legal(CHANNELS, DEPTH, DATA_WIDTH, OUT_WIDTH)) begin : g_param_check
      $fatal(1, "reg_chain_sum_pipe: parameters out of legal range");
   end

   // Index 0 is the pipe input; index i+1 is the output of stage i.
   logic [DEPTH:0][LANES_W-1:0] w_data;
   logic [DEPTH:0]              w_vld;
   logic [DEPTH-1:0]            w_adv;
   logic [OUT_WIDTH-1:0]        w_sum;
   logic [CNT_WIDTH-1:0]        r_cnt;

   assign w_data[0] = in_data;
   assign w_vld[0]  = in_vld;

   // Ready ripples back from the consumer; an empty stage always advances.
   always_comb begin
      w_adv            = '0;
      w_adv[DEPTH-1]   = !w_vld[DEPTH] | out_rdy;
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         w_adv[i] = !w_vld[i+1] | w_adv[i+1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      reg_chain_sum_stage #(
         .LANES_W (LANES_W)
      ) u_stage (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .i_clr   (clr),
         .i_adv   (w_adv[i]),
         .i_data  (w_data[i]),
         .i_vld   (w_vld[i]),
         .o_data  (w_data[i+1]),
         .o_vld   (w_vld[i+1])
      );
   end

   always_comb begin
      w_sum = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         w_sum = w_sum + OUT_WIDTH'(w_data[DEPTH][lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]);
      end
   end

   // A handshake coinciding with clr still counts: the consumer already took it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_vld[DEPTH] && out_rdy) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign in_rdy   = w_adv[0];
   assign out_vld  = w_vld[DEPTH];
   assign out_data = w_sum;
   assign out_cnt  = r_cnt;

endmodule
